// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by both the master and the target: field widths,
// R/W encoding, the target FSM state set and a saturating counter helper.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } i2c_state_t;

    function automatic logic [I2C_BYTE_W-1:0] sat_inc(input logic [I2C_BYTE_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the clk domain and flags SCL edges plus START/STOP
// conditions, all from the synchronized copies only.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic                   w_scl;
    logic                   w_sda;

    // NOTE: synchronizers reset to 1 so a reset looks like an idle bus, not a START.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign o_sda      = w_sda;
    assign o_scl_rise = w_scl & ~r_scl_d;
    assign o_scl_fall = ~w_scl & r_scl_d;
    assign o_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign o_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target: answers SLAVE_ADDR, accepts written bytes and returns user bytes
// on reads. SDA is only ever changed just after an SCL falling edge.
module i2c_slave_responder
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [I2C_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [I2C_BYTE_W-1:0] tx_data,
    output logic                  tx_req,
    output logic                  busy,
    output logic [I2C_BYTE_W-1:0] byte_count
);

    logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst        (rst),
        .i_scl      (scl_in),
        .i_sda      (sda_in),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    i2c_state_t            r_state, w_state_nx;
    logic [3:0]            r_bit_cnt, w_bit_cnt_nx;
    logic [I2C_BYTE_W-1:0] r_shift, w_shift_nx;
    logic [I2C_BYTE_W-1:0] r_tx_shift, w_tx_shift_nx;
    logic [I2C_BYTE_W-1:0] r_rx_data, w_rx_data_nx;
    logic [I2C_BYTE_W-1:0] r_byte_count, w_byte_count_nx;
    logic                  r_sda_oe, w_sda_oe_nx;
    logic                  r_rx_valid, w_rx_valid_nx;
    logic                  r_tx_req, w_tx_req_nx;
    logic                  r_busy, w_busy_nx;
    logic                  r_ack_seen, w_ack_seen_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_tx_shift   <= '0;
            r_rx_data    <= '0;
            r_byte_count <= '0;
            r_sda_oe     <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_tx_req     <= 1'b0;
            r_busy       <= 1'b0;
            r_ack_seen   <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_bit_cnt    <= w_bit_cnt_nx;
            r_shift      <= w_shift_nx;
            r_tx_shift   <= w_tx_shift_nx;
            r_rx_data    <= w_rx_data_nx;
            r_byte_count <= w_byte_count_nx;
            r_sda_oe     <= w_sda_oe_nx;
            r_rx_valid   <= w_rx_valid_nx;
            r_tx_req     <= w_tx_req_nx;
            r_busy       <= w_busy_nx;
            r_ack_seen   <= w_ack_seen_nx;
        end
    end

    // NOTE: every next-value gets a default first so no path leaves a latch.
    always_comb begin
        w_state_nx      = r_state;
        w_bit_cnt_nx    = r_bit_cnt;
        w_shift_nx      = r_shift;
        w_tx_shift_nx   = r_tx_shift;
        w_rx_data_nx    = r_rx_data;
        w_byte_count_nx = r_byte_count;
        w_sda_oe_nx     = r_sda_oe;
        w_rx_valid_nx   = 1'b0;
        w_tx_req_nx     = 1'b0;
        w_busy_nx       = r_busy;
        w_ack_seen_nx   = r_ack_seen;

        if (w_stop) begin
            w_state_nx  = ST_IDLE;
            w_sda_oe_nx = 1'b0;
            w_busy_nx   = 1'b0;
        end else if (w_start) begin
            w_state_nx      = ST_ADDR;
            w_bit_cnt_nx    = '0;
            w_byte_count_nx = '0;
            w_sda_oe_nx     = 1'b0;
            w_ack_seen_nx   = 1'b0;
        end else begin
            unique case (r_state)
                ST_ADDR: begin
                    if (w_scl_rise && r_bit_cnt != 4'd8) begin
                        w_shift_nx   = {r_shift[I2C_BYTE_W-2:0], w_sda};
                        w_bit_cnt_nx = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                        if (r_shift[I2C_BYTE_W-1:1] == SLAVE_ADDR) begin
                            w_state_nx  = ST_ADDR_ACK;
                            w_sda_oe_nx = 1'b1;
                            w_busy_nx   = 1'b1;
                        end else begin
                            w_state_nx = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (r_shift[0] == RW_READ) begin
                            w_state_nx    = ST_RD_DATA;
                            w_tx_shift_nx = tx_data;
                            w_tx_req_nx   = 1'b1;
                            w_sda_oe_nx   = ~tx_data[I2C_BYTE_W-1];
                            w_bit_cnt_nx  = 4'd1;
                        end else begin
                            w_state_nx   = ST_WR_DATA;
                            w_sda_oe_nx  = 1'b0;
                            w_bit_cnt_nx = '0;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (w_scl_rise && r_bit_cnt != 4'd8) begin
                        w_shift_nx   = {r_shift[I2C_BYTE_W-2:0], w_sda};
                        w_bit_cnt_nx = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            w_rx_data_nx    = {r_shift[I2C_BYTE_W-2:0], w_sda};
                            w_rx_valid_nx   = 1'b1;
                            w_byte_count_nx = sat_inc(r_byte_count);
                        end
                    end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                        w_state_nx  = ST_WR_ACK;
                        w_sda_oe_nx = 1'b1;
                    end
                end
                ST_WR_ACK: begin
                    if (w_scl_fall) begin
                        w_state_nx   = ST_WR_DATA;
                        w_sda_oe_nx  = 1'b0;
                        w_bit_cnt_nx = '0;
                    end
                end
                ST_RD_DATA: begin
                    if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            w_state_nx    = ST_RD_ACK;
                            w_sda_oe_nx   = 1'b0;
                            w_ack_seen_nx = 1'b0;
                        end else begin
                            w_tx_shift_nx = {r_tx_shift[I2C_BYTE_W-2:0], 1'b0};
                            w_sda_oe_nx   = ~r_tx_shift[I2C_BYTE_W-2];
                            w_bit_cnt_nx  = r_bit_cnt + 4'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (w_scl_rise) begin
                        if (!w_sda) begin
                            w_ack_seen_nx   = 1'b1;
                            w_byte_count_nx = sat_inc(r_byte_count);
                        end else begin
                            w_state_nx = ST_IGNORE;
                        end
                    end else if (w_scl_fall && r_ack_seen) begin
                        w_state_nx    = ST_RD_DATA;
                        w_tx_shift_nx = tx_data;
                        w_tx_req_nx   = 1'b1;
                        w_sda_oe_nx   = ~tx_data[I2C_BYTE_W-1];
                        w_bit_cnt_nx  = 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe     = r_sda_oe;
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign tx_req     = r_tx_req;
    assign busy       = r_busy;
    assign byte_count = r_byte_count;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: a behavioural I2C master drives the bus while a
// monitor scoreboards written bytes and counts tx_req pulses.
module tb_i2c_slave_responder;

    localparam int Q = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req;
    logic       busy;
    logic [7:0] byte_count;

    int         n_checks = 0;
    int         n_errors = 0;
    int         tx_req_cnt = 0;
    bit         tx_auto = 1'b0;
    logic [7:0] exp_rx[$];

    always #5 clk = ~clk;

    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_responder #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .scl_in     (scl_m),
        .sda_in     (sda_line),
        .sda_oe     (sda_oe),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_req     (tx_req),
        .busy       (busy),
        .byte_count (byte_count)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: pops one expected byte per rx_valid pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_valid) begin
                if (exp_rx.size() == 0) begin
                    check("spurious_rx_valid", {24'h0, rx_data}, 32'hFFFF_FFFF);
                end else begin
                    check("rx_data", {24'h0, rx_data}, {24'h0, exp_rx.pop_front()});
                end
            end
            if (tx_req) begin
                tx_req_cnt++;
                if (tx_auto) tx_data = tx_data + 8'd1;
            end
        end
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic i2c_start();
        sda_m = 1'b1; scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; #Q;
        scl_m = 1'b1; #(2*Q);
        scl_m = 1'b0; #Q;
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        b = sda_line; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(nack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        logic       b;

        #(3*Q + 2);
        check("reset_sda_oe", {31'h0, sda_oe}, 32'h0);
        check("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
        check("reset_tx_req", {31'h0, tx_req}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_byte_count", {24'h0, byte_count}, 32'h0);
        check("reset_rx_data", {24'h0, rx_data}, 32'h0);
        rst = 1'b0;
        #(2*Q - 2);

        // Two-byte write to the matching address
        i2c_start();
        write_byte(8'hA0, ack);
        check("wr_addr_ack", {31'h0, ack}, 32'h0);
        check("wr_busy", {31'h0, busy}, 32'h1);
        exp_rx.push_back(8'hA5);
        write_byte(8'hA5, ack);
        check("wr_a5_ack", {31'h0, ack}, 32'h0);
        exp_rx.push_back(8'h3C);
        write_byte(8'h3C, ack);
        check("wr_3c_ack", {31'h0, ack}, 32'h0);
        check("wr_byte_count", {24'h0, byte_count}, 32'h2);
        i2c_stop();
        #Q;
        check("wr_busy_after_stop", {31'h0, busy}, 32'h0);

        // Mismatched address must be ignored
        i2c_start();
        write_byte(8'hA2, ack);
        check("mismatch_addr_nack", {31'h0, ack}, 32'h1);
        write_byte(8'h55, ack);
        check("mismatch_data_nack", {31'h0, ack}, 32'h1);
        check("mismatch_busy", {31'h0, busy}, 32'h0);
        i2c_stop();
        #Q;

        // 32-byte read, NACK on the last
        tx_data = 8'h00;
        tx_auto = 1'b1;
        tx_req_cnt = 0;
        i2c_start();
        write_byte(8'hA1, ack);
        check("rd_addr_ack", {31'h0, ack}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            read_byte(d, (i == 31) ? 1'b1 : 1'b0);
            check($sformatf("rd_byte_%0d", i), {24'h0, d}, i);
        end
        check("rd_sda_released", {31'h0, sda_oe}, 32'h0);
        check("rd_tx_req_count", tx_req_cnt, 32'd32);
        check("rd_byte_count", {24'h0, byte_count}, 32'd31);
        check("rd_busy_before_stop", {31'h0, busy}, 32'h1);
        i2c_stop();
        #Q;
        check("rd_busy_after_stop", {31'h0, busy}, 32'h0);
        tx_auto = 1'b0;

        // Write then repeated START into a read
        tx_data = 8'h77;
        i2c_start();
        write_byte(8'hA0, ack);
        check("rs_addr_w_ack", {31'h0, ack}, 32'h0);
        exp_rx.push_back(8'h11);
        write_byte(8'h11, ack);
        check("rs_11_ack", {31'h0, ack}, 32'h0);
        check("rs_byte_count_1", {24'h0, byte_count}, 32'h1);
        i2c_rstart();
        check("rs_byte_count_cleared", {24'h0, byte_count}, 32'h0);
        write_byte(8'hA1, ack);
        check("rs_addr_r_ack", {31'h0, ack}, 32'h0);
        read_byte(d, 1'b1);
        check("rs_read_data", {24'h0, d}, 32'h77);
        i2c_stop();
        #Q;

        // Reset during bit 4 of a read byte
        tx_data = 8'h00;
        i2c_start();
        write_byte(8'hA1, ack);
        check("rst_addr_ack", {31'h0, ack}, 32'h0);
        for (int i = 0; i < 3; i++) recv_bit(b);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        check("rst_pre_sda_oe", {31'h0, sda_oe}, 32'h1);
        rst = 1'b1;
        #1;
        check("rst_sda_oe_same_cycle", {31'h0, sda_oe}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        #(Q - 1);
        rst = 1'b0;
        #Q;
        scl_m = 1'b0; #Q;
        i2c_stop();
        #Q;
        i2c_start();
        write_byte(8'hA0, ack);
        check("post_rst_addr_ack", {31'h0, ack}, 32'h0);
        exp_rx.push_back(8'h5A);
        write_byte(8'h5A, ack);
        check("post_rst_data_ack", {31'h0, ack}, 32'h0);
        check("post_rst_byte_count", {24'h0, byte_count}, 32'h1);
        i2c_stop();
        #Q;

        // Illegal START mid-byte restarts address phase
        i2c_start();
        write_byte(8'hA0, ack);
        check("ill_addr_ack", {31'h0, ack}, 32'h0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
        write_byte(8'hA0, ack);
        check("ill_start_readdr_ack", {31'h0, ack}, 32'h0);
        exp_rx.push_back(8'h99);
        write_byte(8'h99, ack);
        check("ill_start_data_ack", {31'h0, ack}, 32'h0);
        check("ill_start_byte_count", {24'h0, byte_count}, 32'h1);

        // Illegal STOP mid-byte returns to idle
        send_bit(1'b0);
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #Q;
        check("ill_stop_busy", {31'h0, busy}, 32'h0);
        check("ill_stop_sda_oe", {31'h0, sda_oe}, 32'h0);
        #(4*Q);

        check("scoreboard_drained", exp_rx.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
